// File: rtl/mem_stage_pipe.sv
// MEM stage: EX/MEM and MEM/WB registers, req/ack data-memory access, load/store lane handling.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses trap (no request, mem_err pulse) instead of truncating.
module mem_stage_pipe #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [2:0]  ex_funct3,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [4:0]  ex_mem_rd,
  output logic        ex_mem_regwrite,
  output logic [31:0] ex_mem_aluresult,
  output logic        ex_mem_is_load,
  output logic [4:0]  mem_wb_rd,
  output logic        mem_wb_regwrite,
  output logic [31:0] wb_result,
  output logic        mem_err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_em_memread, r_em_memwrite;
  logic [31:0]        r_em_sdata;
  logic [2:0]         r_em_funct3;

  logic               w_memop, w_mis, w_ack, w_timeout, w_complete, w_fail;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load_data;

  // Next state, memory interface and stall decode
  always_comb begin
    w_next      = r_state;
    w_memop     = r_em_memread | r_em_memwrite;
    w_mis       = 1'b0;
`ifdef MISALIGN_TRAP_EN
    w_mis       = w_memop &
                  (((r_em_funct3[1:0] == 2'b01) & ex_mem_aluresult[0]) |
                   ((r_em_funct3[1:0] == 2'b10) & (ex_mem_aluresult[1:0] != 2'b00)));
`endif
    mem_req     = w_memop & ~w_mis;
    mem_we      = mem_req & r_em_memwrite;
    mem_addr    = {ex_mem_aluresult[31:2], 2'b00};
    mem_wdata   = 32'h0;
    mem_wstrb   = 4'b0000;
    w_ack       = mem_req & mem_ack;
    w_timeout   = (r_state == S_WAIT) & ~w_ack & (r_cnt == CNT_W'(TIMEOUT_CYCLES));
    w_complete  = w_ack | w_timeout | w_mis;
    w_fail      = w_timeout | w_mis;
    stall       = w_memop & ~w_complete;

    if (mem_we) begin
      case (r_em_funct3[1:0])
        2'b00: begin
          mem_wstrb = 4'b0001 << ex_mem_aluresult[1:0];
          mem_wdata = {4{r_em_sdata[7:0]}};
        end
        2'b01: begin
          mem_wstrb = 4'b0011 << {ex_mem_aluresult[1], 1'b0};
          mem_wdata = {2{r_em_sdata[15:0]}};
        end
        default: begin
          mem_wstrb = 4'b1111;
          mem_wdata = r_em_sdata;
        end
      endcase
    end

    case (r_state)
      S_IDLE:  if (mem_req && !w_complete) w_next = S_WAIT;
      S_WAIT:  if (w_complete) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Load lane select and sign/zero extension
  always_comb begin
    w_byte = 8'(mem_rdata >> {ex_mem_aluresult[1:0], 3'b000});
    w_half = ex_mem_aluresult[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_em_funct3[1:0])
      2'b00:   w_load_data = {{24{w_byte[7] & ~r_em_funct3[2]}}, w_byte};
      2'b01:   w_load_data = {{16{w_half[15] & ~r_em_funct3[2]}}, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      mem_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == S_WAIT) ? r_cnt + CNT_W'(1) : '0;
      mem_err <= w_fail;
    end
  end

  // EX/MEM register; writes to r0 never reach forwarding
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem_rd        <= '0;
      ex_mem_regwrite  <= 1'b0;
      ex_mem_aluresult <= '0;
      r_em_memread     <= 1'b0;
      r_em_memwrite    <= 1'b0;
      r_em_sdata       <= '0;
      r_em_funct3      <= '0;
    end else if (!stall) begin
      ex_mem_rd        <= ex_rd;
      ex_mem_regwrite  <= ex_valid & ex_regwrite & (ex_rd != 5'd0);
      ex_mem_aluresult <= ex_alu_result;
      r_em_memread     <= ex_valid & ex_memread;
      r_em_memwrite    <= ex_valid & ex_memwrite;
      r_em_sdata       <= ex_store_data;
      r_em_funct3      <= ex_funct3;
    end
  end

  assign ex_mem_is_load = r_em_memread;

  // MEM/WB register; bubbles while stalled, failed or store ops never write back
  always_ff @(posedge clk) begin
    if (rst || stall) begin
      mem_wb_rd       <= '0;
      mem_wb_regwrite <= 1'b0;
      wb_result       <= '0;
    end else begin
      mem_wb_rd       <= ex_mem_rd;
      mem_wb_regwrite <= ex_mem_regwrite & ~r_em_memwrite & ~w_fail & (ex_mem_rd != 5'd0);
      wb_result       <= r_em_memread ? w_load_data : ex_mem_aluresult;
    end
  end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed self-checking bench for mem_stage_pipe (TIMEOUT_CYCLES = 4).
module tb_mem_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [2:0]  ex_funct3;
  logic        mem_req, mem_we, mem_ack, stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [4:0]  ex_mem_rd, mem_wb_rd;
  logic        ex_mem_regwrite, ex_mem_is_load, mem_wb_regwrite, mem_err;
  logic [31:0] ex_mem_aluresult, wb_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage_pipe #(.TIMEOUT_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_funct3(ex_funct3),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
    .ex_mem_aluresult(ex_mem_aluresult), .ex_mem_is_load(ex_mem_is_load),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .wb_result(wb_result), .mem_err(mem_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [4:0] rd, input logic rw,
                          input logic [31:0] alu, input logic [31:0] sd,
                          input logic rdm, input logic wrm, input logic [2:0] f3);
    ex_valid = v; ex_rd = rd; ex_regwrite = rw; ex_alu_result = alu;
    ex_store_data = sd; ex_memread = rdm; ex_memwrite = wrm; ex_funct3 = f3;
  endtask

  task automatic bubble();
    drive_ex(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000);
  endtask

  int req_cnt, stall_cnt;

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
    bubble();
    tick(); tick();
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    check("rst_wb_rw", 32'(mem_wb_regwrite), 32'd0);
    rst = 1'b0;

    // ADDI x5 = 0x10
    drive_ex(1'b1, 5'd5, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 3'b000);
    tick();
    bubble();
    check("addi_em_rd", 32'(ex_mem_rd), 32'd5);
    check("addi_em_alu", ex_mem_aluresult, 32'h10);
    check("addi_em_rw", 32'(ex_mem_regwrite), 32'd1);
    tick();
    check("addi_wb_rd", 32'(mem_wb_rd), 32'd5);
    check("addi_wb_res", wb_result, 32'h10);
    check("addi_wb_rw", 32'(mem_wb_regwrite), 32'd1);

    // ADDI to x0: write enable suppressed
    drive_ex(1'b1, 5'd0, 1'b1, 32'h55, 32'h0, 1'b0, 1'b0, 3'b000);
    tick();
    bubble();
    check("x0_em_rw", 32'(ex_mem_regwrite), 32'd0);

    // LB x6 @0x103, ack on 4th request cycle
    drive_ex(1'b1, 5'd6, 1'b1, 32'h103, 32'h0, 1'b1, 1'b0, 3'b000);
    tick();
    bubble();
    #1;
    check("lb_addr", mem_addr, 32'h100);
    check("lb_is_load", 32'(ex_mem_is_load), 32'd1);
    check("lb_we", 32'(mem_we), 32'd0);
    req_cnt = 0; stall_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin mem_ack = 1'b1; mem_rdata = 32'h80AABBCC; end
      #1;
      req_cnt   += int'(mem_req);
      stall_cnt += int'(stall);
      if (i < 3) check("lb_em_fwd", 32'(ex_mem_rd), 32'd6);
      tick();
      mem_ack = 1'b0;
      if (i < 3) check("lb_bubble", 32'(mem_wb_regwrite), 32'd0);
    end
    check("lb_req_cycles", 32'(req_cnt), 32'd4);
    check("lb_stall_cycles", 32'(stall_cnt), 32'd3);
    check("lb_wb_res", wb_result, 32'hFFFFFF80);
    check("lb_wb_rw", 32'(mem_wb_regwrite), 32'd1);
    check("lb_wb_rd", 32'(mem_wb_rd), 32'd6);
    check("lb_req_done", 32'(mem_req), 32'd0);

    // LHU x9 @0x102, zero-wait ack
    drive_ex(1'b1, 5'd9, 1'b1, 32'h102, 32'h0, 1'b1, 1'b0, 3'b101);
    tick();
    bubble();
    mem_ack = 1'b1; mem_rdata = 32'h80AABBCC;
    #1;
    check("lhu_stall", 32'(stall), 32'd0);
    tick();
    mem_ack = 1'b0;
    check("lhu_wb_res", wb_result, 32'h000080AA);
    check("lhu_wb_rw", 32'(mem_wb_regwrite), 32'd1);

    // SH 0x1234ABCD @0x202, same-cycle ack
    drive_ex(1'b1, 5'd0, 1'b0, 32'h202, 32'h1234ABCD, 1'b0, 1'b1, 3'b001);
    tick();
    bubble();
    mem_ack = 1'b1;
    #1;
    check("sh_wstrb", 32'(mem_wstrb), 32'h0000000C);
    check("sh_wdata", mem_wdata, 32'hABCDABCD);
    check("sh_we", 32'(mem_we), 32'd1);
    check("sh_addr", mem_addr, 32'h200);
    check("sh_stall", 32'(stall), 32'd0);
    tick();
    mem_ack = 1'b0;
    check("sh_wb_rw", 32'(mem_wb_regwrite), 32'd0);

    // SB 0xEF @0x301 with rd nonzero: store never writes back
    drive_ex(1'b1, 5'd3, 1'b1, 32'h301, 32'h000000EF, 1'b0, 1'b1, 3'b000);
    tick();
    bubble();
    mem_ack = 1'b1;
    #1;
    check("sb_wstrb", 32'(mem_wstrb), 32'h00000002);
    check("sb_wdata", mem_wdata, 32'hEFEFEFEF);
    tick();
    mem_ack = 1'b0;
    check("sb_wb_rw", 32'(mem_wb_regwrite), 32'd0);

    // LW x7 @0x300, no ack: timeout at count 4
    drive_ex(1'b1, 5'd7, 1'b1, 32'h300, 32'h0, 1'b1, 1'b0, 3'b010);
    tick();
    bubble();
    stall_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!stall) break;
      stall_cnt++;
      tick();
    end
    check("to_stall_cycles", 32'(stall_cnt), 32'd5);
    check("to_req_last", 32'(mem_req), 32'd1);
    check("to_err_early", 32'(mem_err), 32'd0);
    tick();
    check("to_err_pulse", 32'(mem_err), 32'd1);
    check("to_wb_rw", 32'(mem_wb_regwrite), 32'd0);
    check("to_req_off", 32'(mem_req), 32'd0);
    tick();
    check("to_err_clear", 32'(mem_err), 32'd0);

    // Reset while in WAIT, then a stray ack
    drive_ex(1'b1, 5'd8, 1'b1, 32'h400, 32'h0, 1'b1, 1'b0, 3'b010);
    tick();
    bubble();
    tick();
    check("rw_stall_pre", 32'(stall), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rw_req", 32'(mem_req), 32'd0);
    check("rw_stall", 32'(stall), 32'd0);
    check("rw_em_rd", 32'(ex_mem_rd), 32'd0);
    check("rw_em_alu", ex_mem_aluresult, 32'h0);
    check("rw_wb_res", wb_result, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    check("rw_late_ack_rw", 32'(mem_wb_regwrite), 32'd0);
    check("rw_late_ack_err", 32'(mem_err), 32'd0);

    // Misaligned LW x10 @0x101
    drive_ex(1'b1, 5'd10, 1'b1, 32'h101, 32'h0, 1'b1, 1'b0, 3'b010);
    tick();
    bubble();
`ifdef MISALIGN_TRAP_EN
    #1;
    check("mis_req", 32'(mem_req), 32'd0);
    check("mis_stall", 32'(stall), 32'd0);
    tick();
    check("mis_err", 32'(mem_err), 32'd1);
    check("mis_wb_rw", 32'(mem_wb_regwrite), 32'd0);
`else
    mem_ack = 1'b1; mem_rdata = 32'h11223344;
    #1;
    check("mis_req", 32'(mem_req), 32'd1);
    check("mis_addr", mem_addr, 32'h100);
    tick();
    mem_ack = 1'b0;
    check("mis_wb_res", wb_result, 32'h11223344);
    check("mis_wb_rw", 32'(mem_wb_regwrite), 32'd1);
    check("mis_err", 32'(mem_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
- Producer side of the operand-forwarding path: holds the EX/MEM and MEM/WB pipeline registers, performs the data-memory access, and drives the forwarding sources consumed by the execute stage.
- Captures EX results and runs loads/stores over a req/ack memory handshake.
- Formats load data and stalls upstream stages while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, maximum wait cycles for mem_ack before the access is abandoned (1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX stage holds a real instruction (0 = bubble)
- ex_rd  in  5  destination register
- ex_regwrite  in  1  instruction writes rd
- ex_alu_result  in  32  ALU result / effective address
- ex_store_data  in  32  forwarded rs2 value for stores
- ex_memread  in  1  load
- ex_memwrite  in  1  store
- ex_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_req  out  1  access request
- mem_we  out  1  1 = store
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  byte enables
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  access complete
- stall  out  1  hold IF/ID/EX and do not advance
- ex_mem_rd  out  5  EX/MEM destination, to forwarding
- ex_mem_regwrite  out  1  EX/MEM write enable, to forwarding
- ex_mem_aluresult  out  32  EX/MEM ALU result, to forwarding
- ex_mem_is_load  out  1  EX/MEM holds a load, to hazard unit
- mem_wb_rd  out  5  MEM/WB destination
- mem_wb_regwrite  out  1  MEM/WB write enable (register-file write strobe)
- wb_result  out  32  write-back value
- mem_err  out  1  one-cycle pulse when an access times out

Behaviour:
- Reset: all EX/MEM and MEM/WB fields are 0. Outputs mem_req, mem_we, mem_wstrb, stall, and mem_err are 0. FSM goes to IDLE and the timeout counter to 0. Reset during WAIT drops mem_req the next cycle with no write-back.
- Write enables to r0: ex_mem_regwrite and mem_wb_regwrite are forced to 0 whenever the corresponding rd == 0.
- EX/MEM register:
  - Loads on every edge with stall == 0.
  - ex_valid == 0 loads a bubble: regwrite, memread, and memwrite all 0.
  - Holds while stall == 1.
- Non-memory instruction: 1-cycle MEM latency. MEM/WB takes wb_result = ex_mem_aluresult at the next edge.
- FSM states: IDLE, WAIT.
- IDLE:
  - If EX/MEM holds a memory op, mem_req = 1 combinationally.
  - mem_ack the same cycle completes with zero wait; otherwise go to WAIT.
- WAIT:
  - mem_req held at 1 with address, data, and strobes stable.
  - Counter increments each cycle.
  - mem_ack returns to IDLE and completes the op.
  - Counter reaching TIMEOUT_CYCLES pulses mem_err, returns to IDLE, and completes the op with mem_wb_regwrite = 0.
- stall = memory op in EX/MEM AND not completing this cycle. Completion means ack, or timeout with no ack.
- While stalled, MEM/WB loads a bubble (regwrite = 0) each edge. The EX/MEM forwarding outputs stay valid.
- Load formatting (addr[1:0] selects the byte/half):
  - B and BU: byte lane. B sign-extends, BU zero-extends.
  - H and HU: half at addr[1]. H sign-extends, HU zero-extends.
  - W: full word.
- Store lanes:
  - B: wstrb = 0001 << addr[1:0], wdata = byte replicated x4.
  - H: wstrb = 0011 << {addr[1],0}, wdata = half replicated x2.
  - W: wstrb = 1111.
- Stores have regwrite forced 0 in MEM/WB.
- Misaligned H/W: address low bits are ignored (only the word/half lane is used) unless the optional feature is enabled.
- mem_ack with no outstanding request is ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN
- Defined:
  - H with addr[0] = 1, or W with addr[1:0] != 0, issues no mem_req.
  - The op completes in 1 cycle with mem_wb_regwrite = 0 and pulses mem_err.
  - No stall is generated.
- Undefined: the access proceeds with truncated lane selection; mem_err is driven only by timeout.

Test Plan:
- ADDI x5 result 0x10, ex_regwrite = 1, ex_rd = 5 -> next cycle ex_mem_rd = 5, ex_mem_aluresult = 0x10; cycle after, mem_wb_rd = 5, wb_result = 0x10, mem_wb_regwrite = 1.
- LB x6 at 0x103, mem_ack after 3 cycles with rdata 0x80AABBCC:
  - mem_req high for 4 cycles, mem_addr = 0x100, stall = 1 for 3 cycles.
  - Then wb_result = 0xFFFFFF80 with mem_wb_regwrite = 1, preceded by 3 bubble cycles.
- SH 0x1234ABCD at 0x202, same-cycle ack -> mem_wstrb = 1100, mem_wdata = 0xABCDABCD, mem_we = 1, stall = 0, no regwrite.
- LW with ack never asserted, TIMEOUT_CYCLES = 4 -> mem_err pulses 1 cycle after the count hits 4, stall drops, mem_wb_regwrite = 0.
- rst asserted in WAIT -> next cycle mem_req = 0, stall = 0, all forwarding outputs 0; a late mem_ack is ignored.
- With MISALIGN_TRAP_EN, LW at 0x101 -> mem_req never asserted, mem_err pulses, mem_wb_regwrite = 0, stall = 0.
